hazard_forward_unit: RTL and testbench

Parametrised data-hazard unit for the 5-stage RISC-V pipeline. Combines EX-stage operand forwarding (MEM > WB priority, x0-safe, write-enable qualified) with a load-use stall FSM that freezes IF/ID and injects EX bubbles for LOAD_LAT cycles. A saturating stall-cycle counter provides performance visibility. Sits beside the ID/EX pipeline register; its outputs drive PC/IF-ID enables, the ID/EX bubble mux and both ALU operand muxes.

---
 rtl/hazard_forward_unit_if.sv | 37 +++
 rtl/hazard_forward_unit.sv | 135 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// Bundle between the ID/EX pipeline control and the hazard/forwarding unit.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_forward_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rs1_id;
    logic [REG_AW-1:0] rs2_id;
    logic [REG_AW-1:0] rs1_ex;
    logic [REG_AW-1:0] rs2_ex;
    logic [REG_AW-1:0] rd_ex;
    logic              memread_ex;
    logic [REG_AW-1:0] rd_mem;
    logic              regwrite_mem;
    logic [REG_AW-1:0] rd_wb;
    logic              regwrite_wb;
    logic              fwd_en;
    logic              flush;
    logic              cnt_clr;
    logic              stall;
    logic              bubble_ex;
    logic [1:0]        mux_alu_1;
    logic [1:0]        mux_alu_2;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, memread_ex,
               rd_mem, regwrite_mem, rd_wb, regwrite_wb, fwd_en, flush, cnt_clr,
        input  stall, bubble_ex, mux_alu_1, mux_alu_2, stall_cnt
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, memread_ex,
               rd_mem, regwrite_mem, rd_wb, regwrite_wb, fwd_en, flush, cnt_clr,
        output stall, bubble_ex, mux_alu_1, mux_alu_2, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding plus load-use stall FSM with a saturating
// stall-cycle counter for the 5-stage pipeline.
module hazard_fwd_lane #(
    parameter int REG_AW = 5
) (
    input  logic              fwd_en_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rd_mem_i,
    input  logic              regwrite_mem_i,
    input  logic [REG_AW-1:0] rd_wb_i,
    input  logic              regwrite_wb_i,
    output logic [1:0]        sel_o
);
    // MEM is the younger producer, so it is checked first.
    always_comb begin
        sel_o = 2'b00;
        if (fwd_en_i && regwrite_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_i))
            sel_o = 2'b10;
        else if (fwd_en_i && regwrite_wb_i && (rd_wb_i != '0) && (rd_wb_i == rs_i))
            sel_o = 2'b01;
    end
endmodule

module hazard_forward_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   arst,
    hazard_forward_unit_if.slave   bus
);
    localparam int              NUM_LANES = 2;
    localparam logic [3:0]      REM_INIT  = 4'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {IDLE, STALL} state_t;

    logic [NUM_LANES-1:0][REG_AW-1:0] rs_ex;
    logic [NUM_LANES-1:0][1:0]        sel;

    assign rs_ex[0] = bus.rs1_ex;
    assign rs_ex[1] = bus.rs2_ex;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        hazard_fwd_lane #(.REG_AW(REG_AW)) u_lane (
            .fwd_en_i       (bus.fwd_en),
            .rs_i           (rs_ex[g]),
            .rd_mem_i       (bus.rd_mem),
            .regwrite_mem_i (bus.regwrite_mem),
            .rd_wb_i        (bus.rd_wb),
            .regwrite_wb_i  (bus.regwrite_wb),
            .sel_o          (sel[g])
        );
    end

    // Outputs are forced inactive combinationally while reset is held.
    assign bus.mux_alu_1 = arst ? 2'b00 : sel[0];
    assign bus.mux_alu_2 = arst ? 2'b00 : sel[1];

    state_t     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       hit;
    logic       stall_raw;

    assign hit = bus.memread_ex && (bus.rd_ex != '0) &&
                 ((bus.rd_ex == bus.rs1_id) || (bus.rd_ex == bus.rs2_id));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Stall asserts in the detection cycle itself, so STALL only covers the
    // remaining LOAD_LAT-1 cycles.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        stall_raw = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        stall_raw = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            rem_d   = REM_INIT;
                        end
                    end
                end
                STALL: begin
                    stall_raw = 1'b1;
                    if (rem_q <= 4'd1) begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    assign bus.stall     = stall_raw & ~arst;
    assign bus.bubble_ex = stall_raw & ~arst;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr)
            cnt_d = '0;
        else if (stall_raw && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: three instances (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4) share one
// stimulus set; expected values are hand-derived constants.
module tb_hazard_forward_unit;
    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       memread_ex, regwrite_mem, regwrite_wb, fwd_en, flush, cnt_clr;

    hazard_forward_unit_if #(.REG_AW(5), .CNT_W(16)) if1 ();
    hazard_forward_unit_if #(.REG_AW(5), .CNT_W(16)) if3 ();
    hazard_forward_unit_if #(.REG_AW(5), .CNT_W(4))  ifc ();

    assign if1.rs1_id = rs1_id;  assign if3.rs1_id = rs1_id;  assign ifc.rs1_id = rs1_id;
    assign if1.rs2_id = rs2_id;  assign if3.rs2_id = rs2_id;  assign ifc.rs2_id = rs2_id;
    assign if1.rs1_ex = rs1_ex;  assign if3.rs1_ex = rs1_ex;  assign ifc.rs1_ex = rs1_ex;
    assign if1.rs2_ex = rs2_ex;  assign if3.rs2_ex = rs2_ex;  assign ifc.rs2_ex = rs2_ex;
    assign if1.rd_ex  = rd_ex;   assign if3.rd_ex  = rd_ex;   assign ifc.rd_ex  = rd_ex;
    assign if1.memread_ex = memread_ex; assign if3.memread_ex = memread_ex; assign ifc.memread_ex = memread_ex;
    assign if1.rd_mem = rd_mem;  assign if3.rd_mem = rd_mem;  assign ifc.rd_mem = rd_mem;
    assign if1.regwrite_mem = regwrite_mem; assign if3.regwrite_mem = regwrite_mem; assign ifc.regwrite_mem = regwrite_mem;
    assign if1.rd_wb  = rd_wb;   assign if3.rd_wb  = rd_wb;   assign ifc.rd_wb  = rd_wb;
    assign if1.regwrite_wb = regwrite_wb; assign if3.regwrite_wb = regwrite_wb; assign ifc.regwrite_wb = regwrite_wb;
    assign if1.fwd_en = fwd_en;  assign if3.fwd_en = fwd_en;  assign ifc.fwd_en = fwd_en;
    assign if1.flush  = flush;   assign if3.flush  = flush;   assign ifc.flush  = flush;
    assign if1.cnt_clr = cnt_clr; assign if3.cnt_clr = cnt_clr; assign ifc.cnt_clr = cnt_clr;

    hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (.clk(clk), .arst(arst), .bus(if1.slave));
    hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_dut3 (.clk(clk), .arst(arst), .bus(if3.slave));
    hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4))  u_dutc (.clk(clk), .arst(arst), .bus(ifc.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0; rd_ex = '0;
        rd_mem = '0; rd_wb = '0; memread_ex = 1'b0; regwrite_mem = 1'b0;
        regwrite_wb = 1'b0; fwd_en = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    endtask

    int n1, n3;

    initial begin
        clr_inputs();
        arst = 1'b1;
        // Hazard and forwarding conditions live during reset.
        memread_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7;
        rs1_ex = 5'd5; rd_mem = 5'd5; regwrite_mem = 1'b1; fwd_en = 1'b1;
        repeat (3) tick();
        chk("rst_stall1",  32'(if1.stall), 32'd0);
        chk("rst_bubble3", 32'(if3.bubble_ex), 32'd0);
        chk("rst_mux1",    32'(if1.mux_alu_1), 32'd0);
        chk("rst_cnt1",    32'(if1.stall_cnt), 32'd0);
        clr_inputs();
        arst = 1'b0;
        tick();

        // Forwarding priority
        fwd_en = 1'b1; rs1_ex = 5'd5; rd_mem = 5'd5; rd_wb = 5'd5;
        regwrite_mem = 1'b1; regwrite_wb = 1'b1; rs2_ex = 5'd3;
        #1 chk("fwd_mem_wins", 32'(if1.mux_alu_1), 32'd2);
        chk("fwd_op2_none", 32'(if1.mux_alu_2), 32'd0);
        regwrite_mem = 1'b0;
        #1 chk("fwd_wb", 32'(if1.mux_alu_1), 32'd1);
        regwrite_mem = 1'b1; rs1_ex = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0;
        #1 chk("fwd_x0", 32'(if1.mux_alu_1), 32'd0);
        rs1_ex = 5'd5; rd_mem = 5'd5; fwd_en = 1'b0;
        #1 chk("fwd_dis", 32'(if1.mux_alu_1), 32'd0);
        fwd_en = 1'b1; rs2_ex = 5'd9; rd_wb = 5'd9; rd_mem = 5'd4;
        #1 chk("fwd_op2_wb", 32'(if1.mux_alu_2), 32'd1);
        chk("fwd_op1_none", 32'(if1.mux_alu_1), 32'd0);
        clr_inputs();
        tick();

        // Load-use: one cycle of hazard, then the load moves on
        memread_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7;
        #1 chk("lu_bubble1", 32'(if1.bubble_ex), 32'd1);
        n1 = 0; n3 = 0;
        for (int i = 0; i < 6; i++) begin
            n1 += int'(if1.stall);
            n3 += int'(if3.stall);
            tick();
            memread_ex = 1'b0;
            #1;
        end
        chk("lu1_cycles", 32'(n1), 32'd1);
        chk("lu1_cnt",    32'(if1.stall_cnt), 32'd1);
        chk("lu3_cycles", 32'(n3), 32'd3);
        chk("lu3_cnt",    32'(if3.stall_cnt), 32'd3);

        memread_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
        #1 chk("lu_x0_nostall", 32'(if3.stall), 32'd0);
        tick();
        chk("lu_x0_cnt", 32'(if3.stall_cnt), 32'd3);
        clr_inputs();

        // Flush in second stall cycle of LOAD_LAT=3
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        memread_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7;
        #1 chk("fl_first", 32'(if3.stall), 32'd1);
        tick();
        memread_ex = 1'b0; flush = 1'b1;
        #1 chk("fl_stall0",  32'(if3.stall), 32'd0);
        chk("fl_bubble0", 32'(if3.bubble_ex), 32'd0);
        tick();
        flush = 1'b0;
        #1 chk("fl_idle", 32'(if3.stall), 32'd0);
        chk("fl_cnt", 32'(if3.stall_cnt), 32'd1);
        memread_ex = 1'b1; flush = 1'b1;
        #1 chk("fl_beats_hit", 32'(if1.stall), 32'd0);
        clr_inputs();

        // Saturation on CNT_W=4
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        memread_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7;
        repeat (20) tick();
        chk("sat_cnt", 32'(ifc.stall_cnt), 32'd15);
        chk("sat_stall", 32'(ifc.stall), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_beats_inc", 32'(ifc.stall_cnt), 32'd0);

        // Async reset while dut3 is stalling
        #2 arst = 1'b1;
        #1 chk("arst_stall3", 32'(if3.stall), 32'd0);
        chk("arst_cnt3", 32'(if3.stall_cnt), 32'd0);
        memread_ex = 1'b0;
        tick();
        arst = 1'b0;
        tick();
        chk("arst_idle3", 32'(if3.stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
